// File: rtl/euler_pkg.sv
// -----------------------------------------------------------------------------
// euler_pkg -- shared definitions for the triangle-number search block.
//   W_DEFAULT : default datapath width of triangle_search
//   state_t   : FSM state register type
//   S_*       : FSM state encodings (fixed values, kept stable for existing
//               waveform viewers and debug scripts)
// -----------------------------------------------------------------------------
package euler_pkg;

  localparam int unsigned W_DEFAULT = 32;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LAUNCH = 3'd1;
  localparam state_t S_SETTLE = 3'd2;
  localparam state_t S_WAIT   = 3'd3;
  localparam state_t S_DONE   = 3'd4;

endpackage

// File: rtl/triangle_search.sv
// -----------------------------------------------------------------------------
// triangle_search -- walks the triangle numbers T(n) = n(n+1)/2 and stops at
// the first one whose divisor count (from an external engine) is strictly
// greater than a threshold.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   go         rising edge launches a search (ignored while one is running)
//   threshold  divisor-count threshold, sampled on the accepted go edge
//   fc_start   one-cycle launch pulse to the divisor-count engine
//   fc_value   candidate presented to the engine, stable LAUNCH..WAIT
//   fc_result  divisor count returned by the engine
//   fc_done    engine-complete level (stale-high until the engine restarts)
//   busy       search in progress
//   done       search ended; held until next accepted go or rst
//   answer     triangle number found (valid when done=1, overflow=0)
//   index      n such that answer = n(n+1)/2
//   overflow   next triangle number would not fit in W bits
//
// Build option:
//   TRIANGLE_SEARCH_BEST_EN  adds best_count / best_value outputs tracking the
//                            largest divisor count seen in the current search.
// -----------------------------------------------------------------------------
module triangle_search
  import euler_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] threshold,
  output logic         fc_start,
  output logic [W-1:0] fc_value,
  input  logic [W-1:0] fc_result,
  input  logic         fc_done,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] answer,
  output logic [W-1:0] index,
  output logic         overflow
`ifdef TRIANGLE_SEARCH_BEST_EN
  ,
  output logic [W-1:0] best_count,
  output logic [W-1:0] best_value
`endif
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state;
  logic         go_q;
  logic         go_edge;
  logic [W-1:0] thr_q;
  logic [W-1:0] tri_q;
  logic [W-1:0] n_q;
  logic [W:0]   tri_next;
  logic         hit;

  always_comb begin
    go_edge  = go & ~go_q;
    // One extra bit so the carry out flags that T(n+1) does not fit.
    tri_next = {1'b0, tri_q} + {1'b0, n_q} + {{W{1'b0}}, 1'b1};
    hit      = fc_result > thr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      go_q     <= 1'b0;
      thr_q    <= '0;
      tri_q    <= '0;
      n_q      <= '0;
      fc_start <= 1'b0;
      fc_value <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      answer   <= '0;
      index    <= '0;
      overflow <= 1'b0;
    end else begin
      go_q <= go;
      case (state)
        S_IDLE, S_DONE: begin
          if (go_edge) begin
            thr_q    <= threshold;
            tri_q    <= ONE;
            n_q      <= ONE;
            done     <= 1'b0;
            answer   <= '0;
            index    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            // fc_start/fc_value are registered, so they are set up on entry
            // to LAUNCH rather than inside it.
            fc_start <= 1'b1;
            fc_value <= ONE;
            state    <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          fc_start <= 1'b0;
          state    <= S_SETTLE;
        end

        // The engine's done level still reflects the previous candidate here.
        S_SETTLE: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (fc_done) begin
            if (hit) begin
              answer <= tri_q;
              index  <= n_q;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end else if (tri_next[W]) begin
              overflow <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= S_DONE;
            end else begin
              tri_q    <= tri_next[W-1:0];
              n_q      <= n_q + ONE;
              fc_start <= 1'b1;
              fc_value <= tri_next[W-1:0];
              state    <= S_LAUNCH;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef TRIANGLE_SEARCH_BEST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      best_count <= '0;
      best_value <= '0;
    end else if ((state == S_IDLE || state == S_DONE) && go_edge) begin
      best_count <= '0;
      best_value <= '0;
    end else if (state == S_WAIT && fc_done && fc_result > best_count) begin
      best_count <= fc_result;
      best_value <= tri_q;
    end
  end
`else
  // No best-candidate tracking in this build.
`endif

endmodule

// File: doc/triangle_search.md
TRIANGLE_SEARCH -- requirements
Module: triangle_search

Interface
REQ-001 SHALL have parameter W, default 32: datapath width of threshold, triangle value, index and divisor count.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port go, input, 1: a rising edge (go=1, previous-cycle go=0) launches a search.
REQ-005 SHALL have port threshold, input, W: the search stops at the first triangle number whose divisor count is strictly greater than this value; sampled on the accepted go edge.
REQ-006 SHALL have port fc_start, output, 1: launch pulse to the external divisor-count engine.
REQ-007 SHALL have port fc_value, output, W: candidate value presented to the engine.
REQ-008 SHALL have port fc_result, input, W: divisor count returned by the engine.
REQ-009 SHALL have port fc_done, input, 1: engine-complete flag (level, stale-high until the engine restarts).
REQ-010 SHALL have port busy, output, 1: a search is in progress.
REQ-011 SHALL have port done, output, 1: the search has ended; held until the next accepted go or rst.
REQ-012 SHALL have port answer, output, W: the triangle number found; valid while done=1 and overflow=0.
REQ-013 SHALL have port index, output, W: n such that answer = n(n+1)/2.
REQ-014 SHALL have port overflow, output, 1: the next triangle number would exceed 2^W-1, so the search ended without a hit.

Function
REQ-015 SHALL implement the FSM states IDLE, LAUNCH, SETTLE, WAIT and DONE.
REQ-016 SHALL, on a go edge in IDLE or DONE, latch threshold, set n=1 and T=1, clear done, answer, index and overflow, set busy=1, and enter LAUNCH.
REQ-017 SHALL ignore a go edge in LAUNCH, SETTLE or WAIT.
REQ-018 SHALL, in LAUNCH, drive fc_start=1 for exactly one cycle with fc_value=T, then enter SETTLE.
REQ-019 SHALL, in SETTLE, drive fc_start=0 and ignore fc_done for exactly one cycle, then enter WAIT, because the engine's done is stale during this window.
REQ-020 SHALL hold fc_value stable at T from LAUNCH through WAIT.
REQ-021 SHALL, in WAIT with fc_done=1 and fc_result > latched threshold (unsigned), set answer=T, index=n, done=1, busy=0, and enter DONE.
REQ-022 SHALL, in WAIT with fc_done=1 otherwise, compute T' = T + n + 1 with a W+1-bit sum; if T' > 2^W-1, set overflow=1, done=1, busy=0 and enter DONE; else set T=T', n=n+1 and enter LAUNCH.
REQ-023 SHALL guarantee fc_start is low for at least one cycle between consecutive launch pulses.
REQ-024 SHALL give a per-candidate overhead of 3 cycles (LAUNCH, SETTLE, the WAIT cycle that observes fc_done), excluding engine latency.
REQ-025 SHALL give the hit check (REQ-021) priority over the overflow check (REQ-022) when both apply to the same candidate.

Reset
REQ-026 SHALL, while rst=1, set state=IDLE, fc_start=0, fc_value=0, busy=0, done=0, answer=0, index=0, overflow=0, and clear the go edge detector to 0.
REQ-027 SHALL apply rst mid-search immediately and discard the in-flight engine result; a go held high through the deassertion of rst counts as an edge.

Configuration
REQ-028 SHALL, with the macro TRIANGLE_SEARCH_BEST_EN defined, add outputs best_count[W] and best_value[W], cleared on rst and on an accepted go and updated whenever fc_result > best_count; these outputs SHALL be absent when the macro is undefined, with all other behaviour identical.

Structure
REQ-029 SHALL place the FSM state encoding and the default W in a shared package, euler_pkg.
REQ-030 SHALL contain no sub-modules; the divisor-count engine is external and is connected through the fc_* ports.
REQ-031 SHALL be accompanied by a verification top that instantiates triangle_search together with the team's divisor-count engine, with an optional tri_step sub-module for the T/n update.

Verification
REQ-032 SHALL cover: threshold=0, go pulse -> done with answer=1, index=1, overflow=0.
REQ-033 SHALL cover: threshold=5 -> answer=28, index=7; a fc_start pulse is observed for each candidate 1, 3, 6, 10, 15, 21, 28.
REQ-034 SHALL cover: threshold=500 -> answer=76576500, index=12375.
REQ-035 SHALL cover: W=8, threshold=200 -> overflow=1, done=1, last fc_value=253 (n=22).
REQ-036 SHALL cover: rst asserted during WAIT, then go with threshold=1 -> answer=3, index=2, with no stale-result hit.
REQ-037 SHALL cover: a go edge during WAIT is ignored; a stale fc_done=1 held high during SETTLE does not advance the FSM.
